// File: rtl/dot_product_engine.sv
// Purpose : fetches n strided A/B byte elements, multiply-accumulates them into a 16-bit sum, writes it as a little-endian word.
// Latency : start accepted in cycle 0 -> mem_we in cycle 3n+1, done in cycle 3n+2; 3 cycles per element.
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
// Ports   : clk/rst (sync, active-high); start + job fields (a_base, a_stride, b_base, b_stride, length, dst_addr);
//           memory port r_addr/r_data (1-cycle read), mem_we/w_addr/w_data; status busy/done/result.
// Option  : define DOT_SATURATE_EN to clamp the accumulator to all-ones on carry-out instead of wrapping.
module dot_product_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   a_base,
    input  logic [ADDR_WIDTH-1:0]   a_stride,
    input  logic [ADDR_WIDTH-1:0]   b_base,
    input  logic [ADDR_WIDTH-1:0]   b_stride,
    input  logic [LEN_WIDTH-1:0]    length,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    output logic [ADDR_WIDTH-1:0]   r_addr,
    input  logic [DATA_WIDTH-1:0]   r_data,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   w_addr,
    output logic [2*DATA_WIDTH-1:0] w_data,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] result
);

    localparam int ACC_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [ADDR_WIDTH-1:0]  a_ptr;
    logic [ADDR_WIDTH-1:0]  b_ptr;
    logic [ADDR_WIDTH-1:0]  a_stride_q;
    logic [ADDR_WIDTH-1:0]  b_stride_q;
    logic [ADDR_WIDTH-1:0]  dst_q;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]  op_a;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ADDR_WIDTH-1:0]  r_addr_q;

    logic [ACC_WIDTH-1:0]   prod;
    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH-1:0]   acc_nxt;

    // r_data in MAC is the B element addressed during RD_B.
    assign prod = {{DATA_WIDTH{1'b0}}, op_a} * {{DATA_WIDTH{1'b0}}, r_data};
    assign sum  = {1'b0, acc} + {1'b0, prod};

`ifdef DOT_SATURATE_EN
    // Once clamped, any further non-zero product carries out again, so the clamp sticks for the job.
    assign acc_nxt = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    assign acc_nxt = sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            a_ptr      <= '0;
            b_ptr      <= '0;
            a_stride_q <= '0;
            b_stride_q <= '0;
            dst_q      <= '0;
            cnt        <= '0;
            op_a       <= '0;
            acc        <= '0;
            result     <= '0;
            r_addr_q   <= '0;
        end else begin
            state    <= state_nxt;
            r_addr_q <= r_addr;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_ptr      <= a_base;
                        b_ptr      <= b_base;
                        a_stride_q <= a_stride;
                        b_stride_q <= b_stride;
                        dst_q      <= dst_addr;
                        cnt        <= length;
                        acc        <= '0;
                    end
                end
                S_RD_B: begin
                    op_a <= r_data;
                end
                S_MAC: begin
                    acc   <= acc_nxt;
                    a_ptr <= a_ptr + a_stride_q;
                    b_ptr <= b_ptr + b_stride_q;
                    cnt   <= cnt - LEN_WIDTH'(1);
                end
                S_WRITE: begin
                    result <= acc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        r_addr    = r_addr_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (length == '0) ? S_WRITE : S_RD_A;
                end
            end
            S_RD_A: begin
                r_addr    = a_ptr;
                state_nxt = S_RD_B;
            end
            S_RD_B: begin
                r_addr    = b_ptr;
                state_nxt = S_MAC;
            end
            S_MAC: begin
                state_nxt = (cnt == LEN_WIDTH'(1)) ? S_WRITE : S_RD_A;
            end
            S_WRITE: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Write port fields are only meaningful while mem_we is high; both registers are zero after reset.
    assign mem_we = (state == S_WRITE);
    assign w_addr = dst_q;
    assign w_data = acc;
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

endmodule

// File: tb/tb_dot_product_engine.sv
// Purpose : self-checking bench for dot_product_engine with a byte-wide memory model on its port.
// Latency : memory reads return one cycle after r_addr; writes land on the edge ending the WRITE cycle.
// Backpressure: none; stimulus is directed vectors with hand-computed expectations.
module tb_dot_product_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a_base, a_stride, b_base, b_stride, length, dst_addr;
    logic [7:0]  r_addr;
    logic [7:0]  r_data;
    logic        mem_we;
    logic [7:0]  w_addr;
    logic [15:0] w_data;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_product_engine dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_base   (a_base),
        .a_stride (a_stride),
        .b_base   (b_base),
        .b_stride (b_stride),
        .length   (length),
        .dst_addr (dst_addr),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .mem_we   (mem_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Memory model: the engine's write has priority; bench preloads go through pk_* while the engine is idle.
    logic [7:0] mem [0:255] = '{default: 8'h00};
    logic       pk_we = 1'b0;
    logic [7:0] pk_addr = 8'h00;
    logic [7:0] pk_dat = 8'h00;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[w_addr]        <= w_data[7:0];
            mem[w_addr + 8'd1] <= w_data[15:8];
        end else begin
            if (pk_we) mem[pk_addr] <= pk_dat;
            r_data <= mem[r_addr];
        end
    end

    // Cycle bookkeeping relative to the cycle a start was presented (cycle 0).
    int         cyc = 0;
    int         c0 = 0;
    int         rel;
    int         we_cnt = 0, done_cnt = 0, we_rel = -1, done_rel = -1;
    logic [7:0] ra_log [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rel = cyc - c0;
        if (mem_we) begin we_cnt++; we_rel = rel; end
        if (done)   begin done_cnt++; done_rel = rel; end
        if (rel >= 0 && rel < 64) ra_log[rel] = r_addr;
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pk_we = 1'b1; pk_addr = a; pk_dat = d;
        @(negedge clk);
        pk_we = 1'b0;
    endtask

    task automatic issue(input logic [7:0] ab, input logic [7:0] as, input logic [7:0] bb,
                         input logic [7:0] bs, input logic [7:0] n, input logic [7:0] dst);
        @(negedge clk);
        a_base = ab; a_stride = as; b_base = bb; b_stride = bs; length = n; dst_addr = dst;
        start = 1'b1;
        c0 = cyc; we_cnt = 0; done_cnt = 0; we_rel = -1; done_rel = -1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        a_base = 8'h0; a_stride = 8'h0; b_base = 8'h0; b_stride = 8'h0; length = 8'h0; dst_addr = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (mem_we !== 1'b0)   begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (r_addr !== 8'h00)  begin errors++; $display("FAIL reset_r_addr got %h want 00", r_addr); end
        checks++; if (w_addr !== 8'h00)  begin errors++; $display("FAIL reset_w_addr got %h want 00", w_addr); end
        checks++; if (w_data !== 16'h0)  begin errors++; $display("FAIL reset_w_data got %h want 0000", w_data); end
        checks++; if (result !== 16'h0)  begin errors++; $display("FAIL reset_result got %h want 0000", result); end
    endtask

    task automatic test_basic();
        poke(8'd10, 8'd2); poke(8'd11, 8'd3); poke(8'd12, 8'd4);
        poke(8'd20, 8'd5); poke(8'd22, 8'd6); poke(8'd24, 8'd7);
        poke(8'd71, 8'hAA);
        issue(8'd10, 8'd1, 8'd20, 8'd2, 8'd3, 8'd70);
        wait_done(60);
        checks++; if (we_rel !== 10)       begin errors++; $display("FAIL basic_we_cycle got %0d want 10", we_rel); end
        checks++; if (done_rel !== 11)     begin errors++; $display("FAIL basic_done_cycle got %0d want 11", done_rel); end
        checks++; if (we_cnt !== 1)        begin errors++; $display("FAIL basic_we_count got %0d want 1", we_cnt); end
        checks++; if (mem[70] !== 8'h38)   begin errors++; $display("FAIL basic_mem70 got %h want 38", mem[70]); end
        checks++; if (mem[71] !== 8'h00)   begin errors++; $display("FAIL basic_mem71 got %h want 00", mem[71]); end
        checks++; if (result !== 16'h0038) begin errors++; $display("FAIL basic_result got %h want 0038", result); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
`ifdef DOT_SATURATE_EN
        exp = 16'hFFFF;
`else
        exp = 16'hFC02;
`endif
        poke(8'd0, 8'd255); poke(8'd1, 8'd255); poke(8'd4, 8'd255); poke(8'd5, 8'd255);
        issue(8'd0, 8'd1, 8'd4, 8'd1, 8'd2, 8'd50);
        wait_done(60);
        checks++; if (result !== exp)        begin errors++; $display("FAIL ovf_result got %h want %h", result, exp); end
        checks++; if (mem[50] !== exp[7:0])  begin errors++; $display("FAIL ovf_mem50 got %h want %h", mem[50], exp[7:0]); end
        checks++; if (mem[51] !== exp[15:8]) begin errors++; $display("FAIL ovf_mem51 got %h want %h", mem[51], exp[15:8]); end
        checks++; if (done_rel !== 8)        begin errors++; $display("FAIL ovf_done_cycle got %0d want 8", done_rel); end
    endtask

    task automatic test_zero_length();
        logic [7:0] ra_before;
        poke(8'd40, 8'h55); poke(8'd41, 8'h55);
        ra_before = r_addr;
        issue(8'd5, 8'd1, 8'd6, 8'd1, 8'd0, 8'd40);
        wait_done(20);
        checks++; if (we_rel !== 1)        begin errors++; $display("FAIL zero_we_cycle got %0d want 1", we_rel); end
        checks++; if (done_rel !== 2)      begin errors++; $display("FAIL zero_done_cycle got %0d want 2", done_rel); end
        checks++; if (mem[40] !== 8'h00)   begin errors++; $display("FAIL zero_mem40 got %h want 00", mem[40]); end
        checks++; if (mem[41] !== 8'h00)   begin errors++; $display("FAIL zero_mem41 got %h want 00", mem[41]); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL zero_result got %h want 0000", result); end
        checks++; if (r_addr !== ra_before) begin errors++; $display("FAIL zero_no_read r_addr got %h want %h", r_addr, ra_before); end
    endtask

    task automatic test_addr_wrap();
        poke(8'd255, 8'd3); poke(8'd0, 8'd4); poke(8'd100, 8'd1); poke(8'd101, 8'd1);
        issue(8'd255, 8'd1, 8'd100, 8'd1, 8'd2, 8'd80);
        wait_done(40);
        checks++; if (ra_log[1] !== 8'd255) begin errors++; $display("FAIL wrap_raddr1 got %0d want 255", ra_log[1]); end
        checks++; if (ra_log[2] !== 8'd100) begin errors++; $display("FAIL wrap_raddr2 got %0d want 100", ra_log[2]); end
        checks++; if (ra_log[4] !== 8'd0)   begin errors++; $display("FAIL wrap_raddr4 got %0d want 0", ra_log[4]); end
        checks++; if (ra_log[5] !== 8'd101) begin errors++; $display("FAIL wrap_raddr5 got %0d want 101", ra_log[5]); end
        checks++; if (result !== 16'd7)     begin errors++; $display("FAIL wrap_result got %0d want 7", result); end
    endtask

    task automatic test_busy_start();
        poke(8'd95, 8'hAA); poke(8'd96, 8'hAA);
        issue(8'd10, 8'd1, 8'd20, 8'd2, 8'd3, 8'd90);
        // Now at cycle 1; present a conflicting job in cycle 2.
        @(negedge clk);
        a_base = 8'd0; b_base = 8'd100; length = 8'd1; dst_addr = 8'd95; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60);
        repeat (0) @(negedge clk);
        checks++; if (result !== 16'h0038) begin errors++; $display("FAIL busy_result got %h want 0038", result); end
        checks++; if (mem[90] !== 8'h38)   begin errors++; $display("FAIL busy_mem90 got %h want 38", mem[90]); end
        checks++; if (mem[95] !== 8'hAA)   begin errors++; $display("FAIL busy_mem95 got %h want AA", mem[95]); end
        checks++; if (done_rel !== 11)     begin errors++; $display("FAIL busy_done_cycle got %0d want 11", done_rel); end
        // Start in the cycle right after done must be accepted.
        issue(8'd10, 8'd1, 8'd20, 8'd2, 8'd1, 8'd92);
        wait_done(20);
        checks++; if (done_rel !== 5)      begin errors++; $display("FAIL b2b_done_cycle got %0d want 5", done_rel); end
        checks++; if (result !== 16'd10)   begin errors++; $display("FAIL b2b_result got %0d want 10", result); end
        checks++; if (mem[92] !== 8'd10)   begin errors++; $display("FAIL b2b_mem92 got %0d want 10", mem[92]); end
    endtask

    task automatic test_reset_mid_job();
        poke(8'd60, 8'hAA);
        issue(8'd10, 8'd1, 8'd20, 8'd2, 8'd3, 8'd60);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (result !== 16'h0)   begin errors++; $display("FAIL rstmid_result got %h want 0000", result); end
        repeat (12) @(negedge clk);
        checks++; if (we_cnt !== 0)       begin errors++; $display("FAIL rstmid_we_count got %0d want 0", we_cnt); end
        checks++; if (done_cnt !== 0)     begin errors++; $display("FAIL rstmid_done_count got %0d want 0", done_cnt); end
        checks++; if (mem[60] !== 8'hAA)  begin errors++; $display("FAIL rstmid_mem60 got %h want AA", mem[60]); end
        issue(8'd10, 8'd1, 8'd20, 8'd2, 8'd3, 8'd60);
        wait_done(60);
        checks++; if (result !== 16'h0038) begin errors++; $display("FAIL rstmid_fresh_result got %h want 0038", result); end
        checks++; if (mem[60] !== 8'h38)   begin errors++; $display("FAIL rstmid_fresh_mem60 got %h want 38", mem[60]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_length();
        test_addr_wrap();
        test_busy_start();
        test_reset_mid_job();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Per-core compute stage sitting directly upstream of the shared data memory; one instance drives one read/write port group (r_addr/r_data, w_addr/w_data, we bit).
- Fetches one row of A and one column of B as 8-bit elements, multiply-accumulates them into a 16-bit sum, and writes the sum back as a little-endian 16-bit word occupying w_addr and w_addr+1.
- Controller issues one job per start pulse and sees busy/done.

Parameters:
- DATA_WIDTH, 8, element width; the accumulator and result are 2*DATA_WIDTH bits.
- ADDR_WIDTH, 8, memory address width; all pointers wrap modulo 2**ADDR_WIDTH.
- LEN_WIDTH, 8, width of the element-count field.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- a_base  in  ADDR_WIDTH  first A element address.
- a_stride  in  ADDR_WIDTH  A address increment per element.
- b_base  in  ADDR_WIDTH  first B element address.
- b_stride  in  ADDR_WIDTH  B address increment per element.
- length  in  LEN_WIDTH  element count n; 0 is legal.
- dst_addr  in  ADDR_WIDTH  result address (low byte); high byte goes to dst_addr+1.
- r_addr  out  ADDR_WIDTH  memory read address.
- r_data  in  DATA_WIDTH  memory read data, valid 1 cycle after r_addr while mem_we=0.
- mem_we  out  1  write enable for this port.
- w_addr  out  ADDR_WIDTH  memory write address.
- w_data  out  2*DATA_WIDTH  result word.
- busy  out  1  high from the cycle after start acceptance through DONE.
- done  out  1  one-cycle pulse when the result is committed.
- result  out  2*DATA_WIDTH  last written sum; held until the next job writes.

Behaviour:
- Reset, and reset mid-operation: state=IDLE; busy, done, and mem_we all 0; r_addr, w_addr, w_data, result, acc, and pointers all 0. Any in-flight job is abandoned and no write is issued.
- IDLE:
  - start=1 latches all job inputs.
  - acc is cleared; a_ptr=a_base, b_ptr=b_base, cnt=length.
  - Next state is RD_A, or WRITE if length==0.
  - start=0 keeps the engine in IDLE.
- RD_A: r_addr=a_ptr, mem_we=0. Next state RD_B.
- RD_B: r_addr=b_ptr; op_a<=r_data. Next state MAC.
- MAC:
  - acc <= acc + op_a*r_data. The product is 2*DATA_WIDTH unsigned; the sum wraps modulo 2**(2*DATA_WIDTH).
  - a_ptr+=a_stride and b_ptr+=b_stride, both wrapping; cnt-=1.
  - Next state WRITE if cnt==1, else RD_A.
- WRITE: mem_we=1 for exactly one cycle; w_addr=dst_addr; w_data=acc; result<=acc. Next state DONE.
- DONE: done=1 for one cycle; busy still 1. Next state IDLE; a start in the following cycle is accepted.
- Latency: with start accepted in cycle 0, mem_we is high in cycle 3n+1 and done in cycle 3n+2. Throughput is 3 cycles per element.
- start while busy is ignored, and job inputs are not re-sampled.
- mem_we is never high outside WRITE, so reads are never suppressed by the memory's write-priority.
- w_addr+1 overflow wraps in memory; the engine does not special-case it.
- r_addr holds its last value outside RD_A/RD_B.

Optional Feature:
- Macro DOT_SATURATE_EN.
- Defined: the MAC add detects carry-out and clamps acc to all-ones (0xFFFF at default width), and acc stays clamped for the remainder of the job.
- Undefined: modulo wrap as above.
- Latency and interface are identical in both builds.

Test Plan:
- Basic: A=[2,3,4] at 10, a_stride=1; B=[5,6,7] at 20, b_stride=2; n=3; dst=70 -> mem[70]=0x38, mem[71]=0x00, result=0x0038, mem_we in cycle 10, done in cycle 11.
- Overflow: A=[255,255] at 0, B=[255,255] at 4, strides 1, n=2 -> w_data=0xFC02 without DOT_SATURATE_EN, 0xFFFF with it.
- Zero length: n=0, dst=40 -> no reads, mem[40]=0x00, mem[41]=0x00, mem_we in cycle 1, done in cycle 2.
- Address wrap: a_base=255, a_stride=1, A: mem[255]=3, mem[0]=4; B=[1,1] at 100; n=2 -> r_addr sequence 255,100,0,101; result=7.
- Busy start: second start pulse in cycle 2 with different bases -> ignored, first job's result unchanged, exactly one done pulse. Next start accepted in the cycle after done.
- Reset mid-job: rst asserted in cycle 4 of an n=3 job -> mem_we never asserted, busy=0 and result=0 the next cycle, a fresh job then completes correctly.
